// File: rtl/div_share_pkg.sv
// Shared types, constants and the round-robin picker for the shared divider controller.
package div_share_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NREQ  = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Wide all-ones value, truncated to the operand width where it is used.
   localparam logic [63:0] DZ_QUOT = '1;

   // Returns the first requester at or after rr (modulo n) whose request bit is set.
   function automatic int unsigned rr_pick(input logic [31:0] req,
                                           input int unsigned n,
                                           input int unsigned rr);
      int unsigned pick;
      int unsigned idx;
      bit          found;
      pick  = rr;
      found = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (!found && (i < n)) begin
            idx = (rr + i) % n;
            if (req[idx[4:0]]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/div_share_ctrl_core.sv
// Iterative restoring divider: one quotient bit per clock, dividend shifted out MSB first.
module div_seq_core
   import div_share_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rset,
   input  logic             start,
   input  logic [WIDTH-1:0] num,
   input  logic [WIDTH-1:0] den,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] nq;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dreg;
   logic [CW-1:0]    cnt;
   logic             active;

   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   diff;
   logic             qbit;
   logic [WIDTH-1:0] rem_next;

   // The borrow out of the WIDTH+1 bit subtraction is the restore decision.
   always_comb begin
      p_shift  = {rem, nq[WIDTH-1]};
      diff     = p_shift - {1'b0, dreg};
      qbit     = ~diff[WIDTH];
      rem_next = qbit ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
      done     = active && (cnt == CW'(WIDTH - 1));
      q        = {nq[WIDTH-2:0], qbit};
      r        = rem_next;
   end

   // nq starts as the dividend and fills with quotient bits from the bottom.
   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         nq     <= '0;
         rem    <= '0;
         dreg   <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         nq     <= num;
         rem    <= '0;
         dreg   <= den;
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         nq  <= q;
         rem <= rem_next;
         cnt <= cnt + CW'(1);
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one iterative divider among NREQ requesters.
module div_share_ctrl
   import div_share_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rset,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] num_i,
   input  logic [NREQ*WIDTH-1:0] den_i,
   output logic [NREQ-1:0]       ack_o,
   output logic [WIDTH-1:0]      q_o,
   output logic [WIDTH-1:0]      r_o,
   output logic                  dz_o,
   output logic [IDW-1:0]        owner_o,
   output logic                  busy_o
);

   state_t           state;
   logic [IDW-1:0]   rr;
   logic [IDW-1:0]   cur;

   logic [IDW-1:0]   pick;
   logic [WIDTH-1:0] pick_num;
   logic [WIDTH-1:0] pick_den;
   logic             start;
   logic             core_done;
   logic [WIDTH-1:0] core_q;
   logic [WIDTH-1:0] core_r;
   logic [IDW-1:0]   rr_next;

   always_comb begin
      pick     = IDW'(rr_pick(32'(req_i), NREQ, 32'(rr)));
      pick_num = num_i[pick*WIDTH +: WIDTH];
      pick_den = den_i[pick*WIDTH +: WIDTH];
      start    = (state == IDLE) && (|req_i) && (pick_den != '0);
      rr_next  = (cur == IDW'(NREQ - 1)) ? '0 : cur + IDW'(1);
   end

   div_seq_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .rset  (rset),
      .start (start),
      .num   (pick_num),
      .den   (pick_den),
      .done  (core_done),
      .q     (core_q),
      .r     (core_r)
   );

   // Divide-by-zero skips the core and publishes its fixed result on the grant edge.
   always_ff @(posedge clk or posedge rset) begin
      if (rset) begin
         state   <= IDLE;
         rr      <= '0;
         cur     <= '0;
         ack_o   <= '0;
         q_o     <= '0;
         r_o     <= '0;
         dz_o    <= 1'b0;
         owner_o <= '0;
         busy_o  <= 1'b0;
      end else begin
         ack_o <= '0;
         unique case (state)
            IDLE: begin
               if (|req_i) begin
                  cur    <= pick;
                  busy_o <= 1'b1;
                  if (pick_den == '0) begin
                     q_o     <= WIDTH'(DZ_QUOT);
                     r_o     <= pick_num;
                     dz_o    <= 1'b1;
                     owner_o <= pick;
                     ack_o   <= NREQ'(1) << pick;
                     state   <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (core_done) begin
                  q_o     <= core_q;
                  r_o     <= core_r;
                  dz_o    <= 1'b0;
                  owner_o <= cur;
                  ack_o   <= NREQ'(1) << cur;
                  state   <= DONE;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               rr     <= rr_next;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl; expected results are queued at request time and popped on ack.
module tb_div_share_ctrl;

   localparam int WIDTH = 16;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   typedef struct {
      int          owner;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rset = 1'b1;
   logic [NREQ-1:0]       req_i = '0;
   logic [NREQ*WIDTH-1:0] num_i = '0;
   logic [NREQ*WIDTH-1:0] den_i = '0;
   logic [NREQ-1:0]       ack_o;
   logic [WIDTH-1:0]      q_o;
   logic [WIDTH-1:0]      r_o;
   logic                  dz_o;
   logic [IDW-1:0]        owner_o;
   logic                  busy_o;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;

   div_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk     (clk),
      .rset    (rset),
      .req_i   (req_i),
      .num_i   (num_i),
      .den_i   (den_i),
      .ack_o   (ack_o),
      .q_o     (q_o),
      .r_o     (r_o),
      .dz_o    (dz_o),
      .owner_o (owner_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("[TB] check %s", tag);
      end
   endtask

   task automatic set_ops(input int k, input logic [15:0] n, input logic [15:0] d);
      num_i[k*WIDTH +: WIDTH] = n;
      den_i[k*WIDTH +: WIDTH] = d;
   endtask

   task automatic push_exp(input int k, input logic [15:0] n, input logic [15:0] d);
      exp_t x;
      x.owner = k;
      x.dz    = (d == 16'd0);
      x.q     = (d == 16'd0) ? 16'hFFFF : n / d;
      x.r     = (d == 16'd0) ? n : n % d;
      sb.push_back(x);
   endtask

   task automatic apply_stimulus(input int k, input logic [15:0] n, input logic [15:0] d);
      @(posedge clk);
      #1;
      set_ops(k, n, d);
      push_exp(k, n, d);
      req_i[k] = 1'b1;
   endtask

   // Counts rising edges until ack_o[k] is seen on a falling edge, bounded.
   task automatic wait_ack(input int k, input int exp_edges, input bit chk_busy, input bit drop);
      int edges = 0;
      bit seen  = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (chk_busy && edges == 4) check_output("busy_run", 32'(busy_o), 32'd1);
         if (ack_o[k]) seen = 1'b1;
      end
      check_output($sformatf("ack%0d_seen", k), 32'(seen), 32'd1);
      if (exp_edges > 0) check_output($sformatf("latency%0d", k), 32'(edges), 32'(exp_edges));
      if (drop) req_i[k] = 1'b0;
   endtask

   // Scoreboard side: every ack pops one expected result.
   always @(negedge clk) begin
      if (!rset && ack_o != '0) begin
         if (sb.size() == 0) begin
            check_output("unexpected_ack", 32'(ack_o), 32'd0);
         end else begin
            e = sb.pop_front();
            check_output("ack_onehot", 32'(ack_o), 32'(1) << e.owner);
            check_output("owner", 32'(owner_o), 32'(e.owner));
            check_output("quot", 32'(q_o), 32'(e.q));
            check_output("rem", 32'(r_o), 32'(e.r));
            check_output("dz", 32'(dz_o), 32'(e.dz));
         end
      end
   end

   initial begin
      logic [15:0] bn[4];
      logic [15:0] bd[4];
      bn = '{16'hFFFF, 16'd5, 16'd0, 16'd1234};
      bd = '{16'hFFFF, 16'd9, 16'd3, 16'd1};

      @(negedge clk);
      check_output("rst_ack", 32'(ack_o), 32'd0);
      check_output("rst_q", 32'(q_o), 32'd0);
      check_output("rst_r", 32'(r_o), 32'd0);
      check_output("rst_dz", 32'(dz_o), 32'd0);
      check_output("rst_owner", 32'(owner_o), 32'd0);
      check_output("rst_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      rset = 1'b0;

      $display("[TB] single request 100/7");
      apply_stimulus(0, 16'd100, 16'd7);
      wait_ack(0, WIDTH + 1, 1'b1, 1'b1);

      $display("[TB] divide by zero 55/0");
      apply_stimulus(2, 16'd55, 16'd0);
      wait_ack(2, 1, 1'b0, 1'b1);

      $display("[TB] boundary operands on requester 3");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(3, bn[i], bd[i]);
         wait_ack(3, WIDTH + 1, 1'b1, 1'b1);
      end

      $display("[TB] contention with all requests held");
      @(posedge clk);
      #1;
      set_ops(0, 16'd1000, 16'd10);
      set_ops(1, 16'd777, 16'd5);
      set_ops(2, 16'd60000, 16'd123);
      set_ops(3, 16'd65535, 16'd2);
      push_exp(0, 16'd1000, 16'd10);
      push_exp(1, 16'd777, 16'd5);
      push_exp(2, 16'd60000, 16'd123);
      push_exp(3, 16'd65535, 16'd2);
      push_exp(0, 16'd1000, 16'd10);
      req_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_ack(i % 4, (i == 0) ? WIDTH + 1 : WIDTH + 2, 1'b1, 1'b0);
      end
      req_i = '0;

      $display("[TB] reset in the middle of an operation");
      @(posedge clk);
      #1;
      set_ops(1, 16'd1000, 16'd3);
      req_i[1] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rset  = 1'b1;
      req_i = '0;
      @(negedge clk);
      check_output("midrst_ack", 32'(ack_o), 32'd0);
      check_output("midrst_q", 32'(q_o), 32'd0);
      check_output("midrst_r", 32'(r_o), 32'd0);
      check_output("midrst_dz", 32'(dz_o), 32'd0);
      check_output("midrst_owner", 32'(owner_o), 32'd0);
      check_output("midrst_busy", 32'(busy_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rset = 1'b0;

      // With rr back at 0, requester 0 must win before requester 1.
      @(posedge clk);
      #1;
      set_ops(0, 16'd9, 16'd4);
      set_ops(1, 16'd1000, 16'd3);
      push_exp(0, 16'd9, 16'd4);
      push_exp(1, 16'd1000, 16'd3);
      req_i = 4'b0011;
      wait_ack(0, WIDTH + 1, 1'b1, 1'b1);
      wait_ack(1, WIDTH + 2, 1'b1, 1'b1);

      $display("[TB] late arrival during RUN");
      apply_stimulus(0, 16'd200, 16'd7);
      repeat (3) @(posedge clk);
      #1;
      set_ops(0, 16'd999, 16'd1);
      set_ops(1, 16'd50, 16'd5);
      push_exp(1, 16'd50, 16'd5);
      req_i[1] = 1'b1;
      wait_ack(0, 0, 1'b1, 1'b1);
      wait_ack(1, WIDTH + 2, 1'b1, 1'b1);

      repeat (5) @(posedge clk);
      @(negedge clk);
      check_output("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
